// File: rtl/pac_motion_ctrl.sv
// pac_motion_ctrl
//   Pac-Man motion controller. Decodes direction requests from the keypad and
//   the PS/2 keyboard, buffers one pending turn, and advances the sprite one
//   pixel per step tick. Every turn and every forward step is first cleared
//   through a req/ack query to an external collision checker.
//
// Configuration macro: TUNNEL_WRAP_EN
//   defined   : stepping off X_MIN/X_MAX wraps to the opposite edge
//   undefined : X saturates at X_MIN/X_MAX and the blocked step clears moving
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   run               motion enable (ticks ignored while low)
//   key_code/ready    keypad scan code and level-valid
//   ps2_code/ready    PS/2 scan code and level-valid (wins on a tie)
//   chk_req           collision query request (Moore)
//   chk_x/y/dir       query position and direction, stable while chk_req=1
//   chk_ack/clear     checker answer; clear valid only with ack
//   pac_x/pac_y       sprite position
//   dir               heading: 00 up, 01 down, 10 left, 11 right
//   moving            last step succeeded
//   turn_pending      a buffered turn is waiting
module pac_motion_ctrl #(
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9,
  parameter int unsigned X_INIT   = 320,
  parameter int unsigned Y_INIT   = 146,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = 639,
  parameter int unsigned STEP_DIV = 262144
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [4:0]    key_code,
  input  logic          key_ready,
  input  logic [7:0]    ps2_code,
  input  logic          ps2_ready,
  output logic          chk_req,
  output logic [XW-1:0] chk_x,
  output logic [YW-1:0] chk_y,
  output logic [1:0]    chk_dir,
  input  logic          chk_ack,
  input  logic          chk_clear,
  output logic [XW-1:0] pac_x,
  output logic [YW-1:0] pac_y,
  output logic [1:0]    dir,
  output logic          moving,
  output logic          turn_pending
);

  localparam int unsigned CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [XW-1:0] LP_X_MIN    = XW'(X_MIN);
  localparam logic [XW-1:0] LP_X_MAX    = XW'(X_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHK_TURN,
    S_CHK_LINE,
    S_MOVE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_key_rdy_d;
  logic          r_ps2_rdy_d;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [1:0]    r_dir;
  logic [1:0]    r_pend_dir;
  logic          r_turn_pending;
  logic          r_moving;
  logic          r_chk_req;
  logic [1:0]    r_chk_dir;

  logic          w_tick;
  logic          w_key_vld;
  logic [1:0]    w_key_dir;
  logic          w_ps2_vld;
  logic [1:0]    w_ps2_dir;
  logic          w_code_vld;
  logic [1:0]    w_code_dir;
  logic          w_turn_ok;
  logic [1:0]    w_dir_nxt;
  logic [1:0]    w_pend_dir_nxt;
  logic          w_tp_nxt;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] w_y_nxt;
  logic          w_step_ok;

  assign w_tick = (r_cnt == LP_CNT_LAST);

  // Rising-edge scan-code decode, one detector per source.
  always_comb begin
    w_key_vld = 1'b0;
    w_key_dir = 2'b00;
    if (key_ready && !r_key_rdy_d) begin
      case (key_code)
        5'h0C:   begin w_key_vld = 1'b1; w_key_dir = 2'b10; end
        5'h0E:   begin w_key_vld = 1'b1; w_key_dir = 2'b11; end
        5'h09:   begin w_key_vld = 1'b1; w_key_dir = 2'b00; end
        5'h11:   begin w_key_vld = 1'b1; w_key_dir = 2'b01; end
        default: begin w_key_vld = 1'b0; w_key_dir = 2'b00; end
      endcase
    end
  end

  always_comb begin
    w_ps2_vld = 1'b0;
    w_ps2_dir = 2'b00;
    if (ps2_ready && !r_ps2_rdy_d) begin
      case (ps2_code)
        8'h6B:   begin w_ps2_vld = 1'b1; w_ps2_dir = 2'b10; end
        8'h74:   begin w_ps2_vld = 1'b1; w_ps2_dir = 2'b11; end
        8'h75:   begin w_ps2_vld = 1'b1; w_ps2_dir = 2'b00; end
        8'h72:   begin w_ps2_vld = 1'b1; w_ps2_dir = 2'b01; end
        default: begin w_ps2_vld = 1'b0; w_ps2_dir = 2'b00; end
      endcase
    end
  end

  assign w_code_vld = w_ps2_vld | w_key_vld;
  assign w_code_dir = w_ps2_vld ? w_ps2_dir : w_key_dir;

  // Heading / pending-turn update. An accepted turn applies the direction that
  // was actually queried; a fresh key event in the same cycle takes priority.
  // Pending is only retired if it was not overwritten while the query ran.
  always_comb begin
    w_turn_ok      = (r_state == S_CHK_TURN) && chk_ack && chk_clear;
    w_dir_nxt      = r_dir;
    w_pend_dir_nxt = r_pend_dir;
    w_tp_nxt       = r_turn_pending;
    if (w_turn_ok) begin
      w_dir_nxt = r_chk_dir;
      if (r_pend_dir == r_chk_dir) w_tp_nxt = 1'b0;
    end
    if (w_code_vld) begin
      if (w_code_dir == r_dir) begin
        w_tp_nxt = 1'b0;
      end else if (w_code_dir == {r_dir[1], ~r_dir[0]}) begin
        w_dir_nxt = w_code_dir;
        w_tp_nxt  = 1'b0;
      end else begin
        w_pend_dir_nxt = w_code_dir;
        w_tp_nxt       = 1'b1;
      end
    end
  end

  // One-pixel step in the current heading with edge handling.
  always_comb begin
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_step_ok = 1'b1;
    case (r_dir)
      2'b00: begin
        if (r_y == '0) w_step_ok = 1'b0;
        else           w_y_nxt   = r_y - YW'(1);
      end
      2'b01: begin
        if (r_y == '1) w_step_ok = 1'b0;
        else           w_y_nxt   = r_y + YW'(1);
      end
      2'b10: begin
        if (r_x == LP_X_MIN) begin
`ifdef TUNNEL_WRAP_EN
          w_x_nxt   = LP_X_MAX;
`else
          w_step_ok = 1'b0;
`endif
        end else begin
          w_x_nxt = r_x - XW'(1);
        end
      end
      default: begin
        if (r_x == LP_X_MAX) begin
`ifdef TUNNEL_WRAP_EN
          w_x_nxt   = LP_X_MIN;
`else
          w_step_ok = 1'b0;
`endif
        end else begin
          w_x_nxt = r_x + XW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_key_rdy_d    <= 1'b0;
      r_ps2_rdy_d    <= 1'b0;
      r_x            <= XW'(X_INIT);
      r_y            <= YW'(Y_INIT);
      r_dir          <= 2'b00;
      r_pend_dir     <= 2'b00;
      r_turn_pending <= 1'b0;
      r_moving       <= 1'b0;
      r_chk_req      <= 1'b0;
      r_chk_dir      <= 2'b00;
    end else begin
      r_key_rdy_d    <= key_ready;
      r_ps2_rdy_d    <= ps2_ready;
      r_cnt          <= w_tick ? '0 : r_cnt + CW'(1);
      r_dir          <= w_dir_nxt;
      r_pend_dir     <= w_pend_dir_nxt;
      r_turn_pending <= w_tp_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_tick && run) begin
            r_chk_req <= 1'b1;
            if (r_turn_pending) begin
              r_state   <= S_CHK_TURN;
              r_chk_dir <= r_pend_dir;
            end else begin
              r_state   <= S_CHK_LINE;
              r_chk_dir <= w_dir_nxt;
            end
          end
        end
        S_CHK_TURN: begin
          if (chk_ack) begin
            r_state   <= S_CHK_LINE;
            r_chk_dir <= w_dir_nxt;
          end
        end
        S_CHK_LINE: begin
          if (chk_ack) begin
            r_chk_req <= 1'b0;
            if (chk_clear) begin
              r_state <= S_MOVE;
            end else begin
              r_moving <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
        S_MOVE: begin
          r_x      <= w_x_nxt;
          r_y      <= w_y_nxt;
          r_moving <= w_step_ok;
          r_state  <= S_IDLE;
        end
        default: begin
          r_chk_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign chk_req      = r_chk_req;
  assign chk_x        = r_x;
  assign chk_y        = r_y;
  assign chk_dir      = r_chk_dir;
  assign pac_x        = r_x;
  assign pac_y        = r_y;
  assign dir          = r_dir;
  assign moving       = r_moving;
  assign turn_pending = r_turn_pending;

endmodule
